// File: rtl/booth_mac_sequencer.sv
// booth_mac_sequencer: operand sequencer and signed accumulator around a fixed-latency 4-bit Booth multiplier.
// Optional macro BOOTH_MAC_SAT_EN selects a saturating accumulator instead of a wrapping one.  Rev 1.0
`default_nettype none

module booth_mac_sequencer #(
    parameter int MUL_LAT = 6,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             acc_clr,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    output logic             busy,
    output logic             ovf
);

    localparam logic [3:0] CNT_LOAD  = 4'(MUL_LAT - 1);
    localparam bit         SKIP_WAIT = (MUL_LAT == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACC   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = SKIP_WAIT ? ACC : WAIT;
            end
            WAIT: begin
                // Leave on the edge where the decremented count reaches zero,
                // so ACC coincides with the product becoming valid.
                if (cnt <= 4'd1) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_add;
    logic             pos_ovf;
    logic             neg_ovf;

    assign p_ext   = ACC_W'(signed'(mul_p));
    assign sum     = acc + p_ext;
    assign pos_ovf = !acc[ACC_W-1] && !p_ext[ACC_W-1] &&  sum[ACC_W-1];
    assign neg_ovf =  acc[ACC_W-1] &&  p_ext[ACC_W-1] && !sum[ACC_W-1];

`ifdef BOOTH_MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        acc_add = sum;
        if (pos_ovf) begin
            acc_add = ACC_MAX;
        end else if (neg_ovf) begin
            acc_add = ACC_MIN;
        end
    end
`else
    assign acc_add = sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a     <= 4'd0;
            mul_b     <= 4'd0;
            cnt       <= 4'd0;
            acc       <= '0;
            ovf       <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= (state == ACC);

            if (state == IDLE && in_valid) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end

            if (state == ISSUE) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // A clear in the ACC cycle still keeps the product that arrives with it.
            if (acc_clr) begin
                acc <= (state == ACC) ? p_ext : '0;
                ovf <= 1'b0;
            end else if (state == ACC) begin
                acc <= acc_add;
                if (pos_ovf || neg_ovf) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_mac_sequencer.sv
// Self-checking bench for booth_mac_sequencer: a 12-bit and an 8-bit accumulator instance share stimulus
// and a latency-accurate multiplier model; results are checked against an arithmetic reference.
`default_nettype none

module tb_booth_mac_sequencer;

    localparam int MUL_LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, acc_clr;
    logic [3:0]  in_a, in_b;
    logic [7:0]  mul_p;

    logic        in_ready, mul_start, acc_valid, busy, ovf;
    logic [3:0]  mul_a, mul_b;
    logic [11:0] acc;

    logic        in_ready8, mul_start8, acc_valid8, busy8, ovf8;
    logic [3:0]  mul_a8, mul_b8;
    logic [7:0]  acc8;

    booth_mac_sequencer #(.MUL_LAT(MUL_LAT), .ACC_W(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .acc(acc),
        .acc_valid(acc_valid), .busy(busy), .ovf(ovf)
    );

    booth_mac_sequencer #(.MUL_LAT(MUL_LAT), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .mul_start(mul_start8),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p), .acc(acc8),
        .acc_valid(acc_valid8), .busy(busy8), .ovf(ovf8)
    );

    // Multiplier model: product valid exactly MUL_LAT edges after start is sampled, junk otherwise.
    int         pend = -1;
    logic [7:0] prod;
    logic [7:0] junk;
    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (mul_start) begin
            prod <= 8'(int'($signed(mul_a)) * int'($signed(mul_b)));
            pend <= MUL_LAT - 1;
        end else if (pend >= 0) begin
            pend <= pend - 1;
        end
    end
    assign mul_p = (pend == 0) ? prod : junk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint m12 = 0, m8 = 0;
    bit     o12 = 0, o8 = 0;

    task automatic ref_acc(input int w, inout longint acc_m, inout bit ovf_m, input int p, input bit clr);
        longint s, mx, mn;
        if (clr) begin
            acc_m = 0;
            ovf_m = 1'b0;
        end
        s  = acc_m + p;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        if (s > mx || s < mn) begin
            ovf_m = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
        end
        acc_m = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: handshake now, fixed-latency checks, ends in the cycle in_ready is back.
    task automatic run_pair(input int a, input int b, input bit clr_acc);
        int starts, first, bad;
        starts = 0; first = -1; bad = 0;
        in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b);
        step();
        in_valid = 1'b0;
        for (int c = 0; c <= MUL_LAT; c++) begin
            if (mul_start) begin
                starts++;
                if (first < 0) first = c;
            end
            if (mul_a !== 4'(a) || mul_b !== 4'(b) || in_ready !== 1'b0 || busy !== 1'b1 ||
                acc_valid !== 1'b0 || acc_valid8 !== 1'b0) bad++;
            in_a = 4'($urandom); in_b = 4'($urandom); in_valid = 1'($urandom);
            if (c == MUL_LAT) begin
                in_valid = 1'b0;
                acc_clr  = clr_acc;
            end
            step();
        end
        acc_clr = 1'b0;
        ref_acc(12, m12, o12, a * b, clr_acc);
        ref_acc(8,  m8,  o8,  a * b, clr_acc);

        n_cmp++;
        if (starts !== 1 || first !== 0) begin
            n_err++;
            $display("FAIL start_pulse a=%0d b=%0d: got %0d pulses first at %0d, want 1 at 0", a, b, starts, first);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL busy_window a=%0d b=%0d: %0d bad cycles, want 0", a, b, bad);
        end
        n_cmp++;
        if (acc_valid !== 1'b1 || acc_valid8 !== 1'b1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL done_flags a=%0d b=%0d: acc_valid=%b/%b in_ready=%b, want 1/1 1",
                     a, b, acc_valid, acc_valid8, in_ready);
        end
        n_cmp++;
        if (acc !== 12'(m12) || ovf !== o12) begin
            n_err++;
            $display("FAIL acc12 a=%0d b=%0d: got %0d ovf=%b, want %0d ovf=%b",
                     a, b, $signed(acc), ovf, m12, o12);
        end
        n_cmp++;
        if (acc8 !== 8'(m8) || ovf8 !== o8) begin
            n_err++;
            $display("FAIL acc8 a=%0d b=%0d: got %0d ovf=%b, want %0d ovf=%b",
                     a, b, $signed(acc8), ovf8, m8, o8);
        end
    endtask

    task automatic idle_clear();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        m12 = 0; m8 = 0; o12 = 1'b0; o8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; in_a = 4'd0; in_b = 4'd0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mul_start !== 1'b0 || acc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b mul_start=%b acc_valid=%b, want 1 0 0 0",
                     in_ready, busy, mul_start, acc_valid);
        end
        n_cmp++;
        if (acc !== 12'd0 || ovf !== 1'b0 || acc8 !== 8'd0 || ovf8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_acc: acc=%0d ovf=%b acc8=%0d ovf8=%b, want 0", acc, ovf, acc8, ovf8);
        end
        n_cmp++;
        if (mul_a !== 4'd0 || mul_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset_ops: mul_a=%0d mul_b=%0d, want 0 0", mul_a, mul_b);
        end
    endtask

    task automatic test_single();
        run_pair(4, 7, 1'b0);
        n_cmp++;
        if (acc !== 12'd28) begin
            n_err++;
            $display("FAIL single_28: acc=%0d, want 28", $signed(acc));
        end
    endtask

    task automatic test_back_to_back();
        run_pair(3, 6, 1'b0);
        n_cmp++;
        if (acc !== 12'd46 || mul_a !== 4'd3) begin
            n_err++;
            $display("FAIL b2b_46: acc=%0d mul_a=%0d, want 46 3", $signed(acc), mul_a);
        end
    endtask

    task automatic test_acc_clr();
        run_pair(2, 4, 1'b1);
        n_cmp++;
        if (acc !== 12'd8 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL clr_in_acc: acc=%0d ovf=%b, want 8 0", $signed(acc), ovf);
        end
        idle_clear();
        n_cmp++;
        if (acc !== 12'd0 || acc8 !== 8'd0 || acc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_idle: acc=%0d acc8=%0d acc_valid=%b, want 0 0 0", acc, acc8, acc_valid);
        end
    endtask

    task automatic test_signed();
        run_pair(-8, -8, 1'b0);
        run_pair(-8, 7, 1'b0);
        run_pair(7, -1, 1'b0);
        n_cmp++;
        if (acc !== 12'd1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL signed_seq: acc=%0d ovf=%b, want 1 0", $signed(acc), ovf);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp8;
`ifdef BOOTH_MAC_SAT_EN
        exp8 = 8'd127;
`else
        exp8 = 8'(-109);
`endif
        idle_clear();
        repeat (3) run_pair(7, 7, 1'b0);
        n_cmp++;
        if (acc8 !== exp8 || ovf8 !== 1'b1 || acc !== 12'd147 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL overflow8: acc8=%0d ovf8=%b acc12=%0d ovf12=%b, want %0d 1 147 0",
                     $signed(acc8), ovf8, $signed(acc), ovf, $signed(exp8));
        end
    endtask

    task automatic test_reset_wait();
        int bad;
        bad = 0;
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m12 = 0; m8 = 0; o12 = 1'b0; o8 = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || acc !== 12'd0 || acc_valid !== 1'b0 || ovf8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wait: busy=%b in_ready=%b acc=%0d acc_valid=%b ovf8=%b, want 0 1 0 0 0",
                     busy, in_ready, acc, acc_valid, ovf8);
        end
        for (int i = 0; i < MUL_LAT + 3; i++) begin
            step();
            if (acc_valid !== 1'b0 || acc !== 12'd0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL discard_product: %0d cycles with activity, want 0", bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 5) == 0) idle_clear();
            run_pair(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                     $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_acc_clr();
        test_signed();
        test_overflow();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
